// File: rtl/psk_link_ctrl.sv
// psk_link_ctrl: link bring-up controller for the PSK Tx/Rx datapath.
// Takes mode/delay reconfiguration requests and drives the shared mode, delay
// and BPSK-select controls. It holds the datapath in reset while flushing,
// then qualifies receiver lock from the Rx valid strobe. It reports link-up,
// timeout, illegal-mode and loss-of-lock status.
module psk_link_ctrl #(
    parameter int RST_CYCLES     = 128,
    parameter int SETTLE_VLD     = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CYCLES    = 1024
) (
    input  logic       clk_16M384,
    input  logic       rst_16M384,
    input  logic       req_vld,
    input  logic [3:0] req_mode,
    input  logic [3:0] req_delay,
    output logic       req_rdy,
    output logic [3:0] MODE_CTRL,
    output logic [3:0] DELAY_CNT,
    output logic       is_bpsk,
    output logic       dp_rst,
    input  logic       rx_vld,
    output logic       link_up,
    output logic [1:0] err,
    output logic [7:0] loss_cnt
);

    // Counter widths: each counter only needs to hold up to its terminal value.
    localparam int FLUSH_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SETTLE_W = $clog2(SETTLE_VLD + 1);
    localparam int GAP_W    = $clog2(LOSS_CYCLES + 1);
    localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [FLUSH_W-1:0]  FLUSH_LOAD  = FLUSH_W'(RST_CYCLES - 1);
    localparam logic [FLUSH_W-1:0]  FLUSH_ZERO  = {FLUSH_W{1'b0}};
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_VLD - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(LOSS_CYCLES - 1);
    localparam logic [GAP_W-1:0]    GAP_FULL    = GAP_W'(LOSS_CYCLES);
    localparam logic [GAP_W-1:0]    GAP_ZERO    = {GAP_W{1'b0}};
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]     TO_ZERO     = {TO_W{1'b0}};

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_ACQ   = 2'd1,
        ST_UP    = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    // Only the two one-hot encodings the datapath implements are legal.
    function automatic logic f_mode_legal(input logic [3:0] mode);
        return (mode == MODE_BPSK) || (mode == MODE_QPSK);
    endfunction

    // Loss-of-lock event counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] f_sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : (val + 8'd1);
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FLUSH_W-1:0]   r_flush_cnt,  w_flush_nxt;
    logic [SETTLE_W-1:0]  r_settle_cnt, w_settle_nxt;
    logic [GAP_W-1:0]     r_gap_cnt,    w_gap_nxt;
    logic [TO_W-1:0]      r_to_cnt,     w_to_nxt;
    logic [3:0]           r_mode,       w_mode_nxt;
    logic [3:0]           r_delay,      w_delay_nxt;
    logic                 r_bpsk,       w_bpsk_nxt;
    logic                 r_dp_rst,     w_dp_rst_nxt;
    logic                 r_link_up,    w_link_nxt;
    logic [1:0]           r_err,        w_err_nxt;
    logic [7:0]           r_loss_cnt,   w_loss_nxt;

    logic                 w_req_rdy;
    logic                 w_accept;
    logic                 w_acq_lock;

    // Requests are only taken once the link has settled (UP) or given up (FAIL).
    assign w_req_rdy  = (r_state == ST_UP) || (r_state == ST_FAIL);
    assign w_accept   = w_req_rdy && req_vld;
    // This edge samples the final strobe needed to qualify lock.
    assign w_acq_lock = rx_vld && (r_settle_cnt == SETTLE_LAST);

    assign req_rdy   = w_req_rdy;
    assign MODE_CTRL = r_mode;
    assign DELAY_CNT = r_delay;
    assign is_bpsk   = r_bpsk;
    assign dp_rst    = r_dp_rst;
    assign link_up   = r_link_up;
    assign err       = r_err;
    assign loss_cnt  = r_loss_cnt;

    // Next-state and next-output logic; a request accept overrides per-state work.
    always_comb begin
        w_state_nxt  = r_state;
        w_flush_nxt  = r_flush_cnt;
        w_settle_nxt = r_settle_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_to_nxt     = r_to_cnt;
        w_mode_nxt   = r_mode;
        w_delay_nxt  = r_delay;
        w_bpsk_nxt   = r_bpsk;
        w_dp_rst_nxt = r_dp_rst;
        w_link_nxt   = r_link_up;
        w_err_nxt    = r_err;
        w_loss_nxt   = r_loss_cnt;

        case (r_state)
            ST_FLUSH: begin
                // Datapath held in reset; rx_vld is meaningless here.
                if (r_flush_cnt == FLUSH_ZERO) begin
                    w_dp_rst_nxt = 1'b0;
                    w_state_nxt  = ST_ACQ;
                    w_settle_nxt = SETTLE_ZERO;
                    w_gap_nxt    = GAP_ZERO;
                    w_to_nxt     = TO_ZERO;
                end else begin
                    w_flush_nxt = r_flush_cnt - FLUSH_W'(1);
                end
            end

            ST_ACQ: begin
                if (rx_vld) begin
                    w_gap_nxt = GAP_ZERO;
                    if (r_settle_cnt != SETTLE_LAST) begin
                        w_settle_nxt = r_settle_cnt + SETTLE_W'(1);
                    end else begin
                        w_settle_nxt = r_settle_cnt;
                    end
                end else if (r_gap_cnt >= GAP_LAST) begin
                    // Strobes too sparse to count as a run: restart qualification.
                    w_gap_nxt    = GAP_FULL;
                    w_settle_nxt = SETTLE_ZERO;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end

                // Lock takes priority over a simultaneous timeout.
                if (w_acq_lock) begin
                    w_state_nxt  = ST_UP;
                    w_link_nxt   = 1'b1;
                    w_gap_nxt    = GAP_ZERO;
                    w_settle_nxt = SETTLE_ZERO;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = ST_FAIL;
                    w_err_nxt   = ERR_TIMEOUT;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end

            ST_UP: begin
                if (rx_vld) begin
                    w_gap_nxt = GAP_ZERO;
                end else if (r_gap_cnt >= GAP_LAST) begin
                    // Loss of lock: requalify without resetting the datapath.
                    w_link_nxt   = 1'b0;
                    w_loss_nxt   = f_sat_inc8(r_loss_cnt);
                    w_state_nxt  = ST_ACQ;
                    w_settle_nxt = SETTLE_ZERO;
                    w_to_nxt     = TO_ZERO;
                    w_gap_nxt    = GAP_ZERO;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            ST_FAIL: begin
                // Parked with config held until a new request is accepted.
                w_state_nxt = ST_FAIL;
            end

            default: begin
                w_state_nxt  = ST_FLUSH;
                w_flush_nxt  = FLUSH_LOAD;
                w_dp_rst_nxt = 1'b1;
                w_link_nxt   = 1'b0;
            end
        endcase

        // An accepted request wins over a same-edge loss event (loss still counted).
        if (w_accept) begin
            if (f_mode_legal(req_mode)) begin
                w_mode_nxt   = req_mode;
                w_delay_nxt  = req_delay;
                w_bpsk_nxt   = (req_mode == MODE_BPSK);
                w_err_nxt    = ERR_NONE;
                w_dp_rst_nxt = 1'b1;
                w_link_nxt   = 1'b0;
                w_state_nxt  = ST_FLUSH;
                w_flush_nxt  = FLUSH_LOAD;
                w_settle_nxt = SETTLE_ZERO;
                w_gap_nxt    = GAP_ZERO;
                w_to_nxt     = TO_ZERO;
            end else begin
                w_err_nxt   = ERR_ILLEGAL;
                w_link_nxt  = 1'b0;
                w_state_nxt = ST_FAIL;
            end
        end else begin
            w_err_nxt = w_err_nxt;
        end
    end

    // State register; reset starts an automatic bring-up in FLUSH.
    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
        if (rst_16M384) begin
            r_flush_cnt  <= FLUSH_LOAD;
            r_settle_cnt <= SETTLE_ZERO;
            r_gap_cnt    <= GAP_ZERO;
            r_to_cnt     <= TO_ZERO;
            r_mode       <= MODE_QPSK;
            r_delay      <= 4'd0;
            r_bpsk       <= 1'b0;
            r_dp_rst     <= 1'b1;
            r_link_up    <= 1'b0;
            r_err        <= ERR_NONE;
            r_loss_cnt   <= 8'd0;
        end else begin
            r_flush_cnt  <= w_flush_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_to_cnt     <= w_to_nxt;
            r_mode       <= w_mode_nxt;
            r_delay      <= w_delay_nxt;
            r_bpsk       <= w_bpsk_nxt;
            r_dp_rst     <= w_dp_rst_nxt;
            r_link_up    <= w_link_nxt;
            r_err        <= w_err_nxt;
            r_loss_cnt   <= w_loss_nxt;
        end
    end

endmodule

// File: tb/tb_psk_link_ctrl.sv
// tb_psk_link_ctrl: directed scoreboard bench for psk_link_ctrl.
// Expected output vectors are pushed when a step is driven and popped and
// compared at the following falling edge.
// Vector layout: {req_rdy, MODE_CTRL, DELAY_CNT, is_bpsk, dp_rst, link_up, err, loss_cnt}.
module tb_psk_link_ctrl;

    logic       clk_16M384;
    logic       rst_16M384;
    logic       req_vld;
    logic [3:0] req_mode;
    logic [3:0] req_delay;
    logic       req_rdy;
    logic [3:0] MODE_CTRL;
    logic [3:0] DELAY_CNT;
    logic       is_bpsk;
    logic       dp_rst;
    logic       rx_vld;
    logic       link_up;
    logic [1:0] err;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    string       q_tag[$];
    logic [21:0] q_exp[$];

    psk_link_ctrl #(
        .RST_CYCLES    (8),
        .SETTLE_VLD    (4),
        .TIMEOUT_CYCLES(64),
        .LOSS_CYCLES   (32)
    ) dut (
        .clk_16M384(clk_16M384),
        .rst_16M384(rst_16M384),
        .req_vld   (req_vld),
        .req_mode  (req_mode),
        .req_delay (req_delay),
        .req_rdy   (req_rdy),
        .MODE_CTRL (MODE_CTRL),
        .DELAY_CNT (DELAY_CNT),
        .is_bpsk   (is_bpsk),
        .dp_rst    (dp_rst),
        .rx_vld    (rx_vld),
        .link_up   (link_up),
        .err       (err),
        .loss_cnt  (loss_cnt)
    );

    initial clk_16M384 = 1'b0;
    always #5 clk_16M384 = ~clk_16M384;

    function automatic logic [21:0] pk(input logic rdy, input logic [3:0] m,
                                       input logic [3:0] d, input logic b,
                                       input logic r, input logic l,
                                       input logic [1:0] e, input logic [7:0] lc);
        return {rdy, m, d, b, r, l, e, lc};
    endfunction

    task automatic sb_push(input string tag, input logic [21:0] e);
        q_tag.push_back(tag);
        q_exp.push_back(e);
    endtask

    task automatic sb_check();
        logic [21:0] obs;
        logic [21:0] e;
        string       tag;
        obs = {req_rdy, MODE_CTRL, DELAY_CNT, is_bpsk, dp_rst, link_up, err, loss_cnt};
        n_cmp++;
        if (q_exp.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed=%h expected=<queued entry>", obs);
        end else begin
            tag = q_tag.pop_front();
            e   = q_exp.pop_front();
            assert (obs === e) else begin
                n_mis++;
                $error("FAIL %s: observed rdy/mode/dly/bpsk/dprst/link/err/loss=%h expected=%h",
                       tag, obs, e);
            end
        end
    endtask

    // One clock edge with rx_vld driven to v, then compare at the falling edge.
    task automatic step(input logic v, input string tag, input logic [21:0] e);
        rx_vld = v;
        sb_push(tag, e);
        @(negedge clk_16M384);
        sb_check();
    endtask

    // Remaining 7 flush edges with dp_rst high, then the edge entering ACQ.
    task automatic flush_seq(input string tag, input logic [21:0] during,
                             input logic [21:0] after);
        for (int i = 0; i < 7; i++) step(1'b0, tag, during);
        step(1'b0, {tag, "_end"}, after);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [21:0] v_rst;
        v_rst = pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);

        rst_16M384 = 1'b1;
        req_vld    = 1'b0;
        req_mode   = 4'b0000;
        req_delay  = 4'd0;
        rx_vld     = 1'b0;
        repeat (2) @(negedge clk_16M384);
        sb_push("reset_state", v_rst);
        sb_check();

        // Bring-up after reset release: 8 cycles of dp_rst, then 4 strobes 16 apart.
        rst_16M384 = 1'b0;
        flush_seq("boot_flush", v_rst, pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0));
        for (int s = 0; s < 3; s++) begin
            step(1'b1, "boot_strobe", pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0));
            for (int k = 0; k < 15; k++) step(1'b0, "boot_gap", pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0));
        end
        step(1'b1, "boot_lock", pk(1'b1, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0));

        // Reconfigure to BPSK, delay 11, then relock at minimum latency.
        req_vld = 1'b1; req_mode = 4'b0001; req_delay = 4'd11;
        step(1'b0, "bpsk_accept", pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b1, 1'b0, 2'b00, 8'd0));
        req_vld = 1'b0;
        flush_seq("bpsk_flush", pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b1, 1'b0, 2'b00, 8'd0),
                  pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0));
        for (int s = 0; s < 3; s++) step(1'b1, "bpsk_acq", pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd0));
        step(1'b1, "bpsk_lock", pk(1'b1, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b1, 2'b00, 8'd0));

        // Loss of lock: 31 quiet cycles keep the link, the 32nd drops it.
        for (int k = 0; k < 31; k++) step(1'b0, "loss_hold", pk(1'b1, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b1, 2'b00, 8'd0));
        step(1'b0, "loss_event", pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1));
        for (int s = 0; s < 3; s++) begin
            step(1'b1, "reacq_strobe", pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1));
            for (int k = 0; k < 9; k++) step(1'b0, "reacq_gap", pk(1'b0, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1));
        end
        step(1'b1, "reacq_lock", pk(1'b1, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b1, 2'b00, 8'd1));

        // Illegal mode from UP: FAIL with err=10, config and dp_rst untouched.
        req_vld = 1'b1; req_mode = 4'b0100; req_delay = 4'd3;
        step(1'b0, "illegal_accept", pk(1'b1, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b10, 8'd1));
        req_vld = 1'b0;
        for (int k = 0; k < 2; k++) step(1'b0, "illegal_hold", pk(1'b1, 4'b0001, 4'd11, 1'b1, 1'b0, 1'b0, 2'b10, 8'd1));

        // Legal request from FAIL clears err.
        req_vld = 1'b1; req_mode = 4'b0010; req_delay = 4'd5;
        step(1'b0, "legal_accept", pk(1'b0, 4'b0010, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 8'd1));
        req_vld = 1'b0;
        flush_seq("legal_flush", pk(1'b0, 4'b0010, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 8'd1),
                  pk(1'b0, 4'b0010, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1));

        // Timeout: no strobes, FAIL with err=01 after 64 ACQ cycles.
        for (int k = 0; k < 63; k++) step(1'b0, "timeout_wait", pk(1'b0, 4'b0010, 4'd5, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1));
        step(1'b0, "timeout_fail", pk(1'b1, 4'b0010, 4'd5, 1'b0, 1'b0, 1'b0, 2'b01, 8'd1));

        // req_vld held through FLUSH/ACQ: second request waits until UP.
        req_vld = 1'b1; req_mode = 4'b0010; req_delay = 4'd6;
        step(1'b0, "held_first", pk(1'b0, 4'b0010, 4'd6, 1'b0, 1'b1, 1'b0, 2'b00, 8'd1));
        req_mode = 4'b0001; req_delay = 4'd9;
        flush_seq("held_flush", pk(1'b0, 4'b0010, 4'd6, 1'b0, 1'b1, 1'b0, 2'b00, 8'd1),
                  pk(1'b0, 4'b0010, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1));
        for (int s = 0; s < 3; s++) step(1'b1, "held_acq", pk(1'b0, 4'b0010, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1));
        step(1'b1, "held_up", pk(1'b1, 4'b0010, 4'd6, 1'b0, 1'b0, 1'b1, 2'b00, 8'd1));
        step(1'b0, "held_accept", pk(1'b0, 4'b0001, 4'd9, 1'b1, 1'b1, 1'b0, 2'b00, 8'd1));
        req_vld = 1'b0;
        flush_seq("held2_flush", pk(1'b0, 4'b0001, 4'd9, 1'b1, 1'b1, 1'b0, 2'b00, 8'd1),
                  pk(1'b0, 4'b0001, 4'd9, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1));
        for (int s = 0; s < 2; s++) step(1'b1, "held2_acq", pk(1'b0, 4'b0001, 4'd9, 1'b1, 1'b0, 1'b0, 2'b00, 8'd1));

        // Asynchronous reset mid-ACQ, checked before the next rising edge.
        #2;
        rst_16M384 = 1'b1;
        sb_push("async_reset", v_rst);
        #1;
        sb_check();
        @(negedge clk_16M384);
        rst_16M384 = 1'b0;

        // Lock on the same edge as the timeout: lock must win.
        flush_seq("coinc_flush", v_rst, pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0));
        for (int k = 0; k < 60; k++) step(1'b0, "coinc_wait", pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0));
        for (int s = 0; s < 3; s++) step(1'b1, "coinc_acq", pk(1'b0, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0));
        step(1'b1, "coinc_lock", pk(1'b1, 4'b0010, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
